// File: rtl/wrapped_delay_counter_pkg.sv
// Shared constants and types for the wrapped delay counter.
// Optional threshold output: WRAPPED_DELAY_COUNTER_THRESHOLD_EN.
package wrapped_delay_counter_pkg;

   localparam int default_width     = 48;
   localparam int default_threshold = 4;

   typedef logic [default_width-1:0] count_t;

endpackage

// File: rtl/delay_counter_core.sv
// Saturating down-counter: load has priority, then decrement to zero.
// Reset is asynchronous and active-low.
module delay_counter_core
   import wrapped_delay_counter_pkg::*;
#(
   parameter int WIDTH = default_width
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] l,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] one = WIDTH'(1);

   logic at_zero;
   assign at_zero = (count == '0);

   // Zero is sticky so the counter never wraps to all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= l;
      end else if (!at_zero) begin
         count <= count - one;
      end
   end

endmodule

// File: rtl/wrapped_delay_counter.sv
// Delay counter wrapper: reset, expired/threshold decode.
// Threshold comparator built only with WRAPPED_DELAY_COUNTER_THRESHOLD_EN.
module wrapped_delay_counter
   import wrapped_delay_counter_pkg::*;
#(
   parameter int WIDTH     = default_width,
   parameter int THRESHOLD = default_threshold
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] l,
   output logic             expired,
   output logic             threshold
);

   logic             rst_n;
   logic [WIDTH-1:0] count;

   assign rst_n = rst;

   delay_counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .l     (l),
      .count (count)
   );

   // Outputs decode the register only, never load or l
   assign expired = (count == '0);

`ifdef WRAPPED_DELAY_COUNTER_THRESHOLD_EN
   localparam logic [WIDTH-1:0] thr = WIDTH'(THRESHOLD);
   assign threshold = (count <= thr);
`else
   assign threshold = 1'b0;
`endif

endmodule

// File: tb/tb_wrapped_delay_counter.sv
// Self-checking bench for wrapped_delay_counter.
// Expected values come from tables and a deadline-based model.
module tb_wrapped_delay_counter;

   localparam int W   = 48;
   localparam int THR = 4;

   logic         clk;
   logic         rst;
   logic         load;
   logic [W-1:0] l;
   logic         expired;
   logic         threshold;

   int tests;
   int fails;

   // Model: remaining = deadline - cycle, floored at zero
   longint unsigned cyc;
   longint unsigned deadline;

   wrapped_delay_counter #(
      .WIDTH     (W),
      .THRESHOLD (THR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .l         (l),
      .expired   (expired),
      .threshold (threshold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         ld;
      logic [W-1:0] lv;
      int           n;
      logic         exp_e;
      logic         exp_t;
   } vec_t;

   function automatic logic thr_en();
`ifdef WRAPPED_DELAY_COUNTER_THRESHOLD_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic longint unsigned remaining();
      return (deadline > cyc) ? deadline - cyc : 64'd0;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   task automatic check_model(string name);
      longint unsigned rem;
      rem = remaining();
      chk({name, "_expired"}, 64'(expired), 64'(rem == 0));
      chk({name, "_thr"}, 64'(threshold),
          64'(thr_en() && (rem <= THR)));
      chk({name, "_count"}, 64'(dut.u_core.count), rem);
   endtask

   task automatic set_rst(logic v);
      rst = v;
      if (!v) deadline = cyc;
   endtask

   // One rising edge; model follows the inputs present at that edge
   task automatic tick();
      logic         r;
      logic         ld;
      logic [W-1:0] lv;
      r  = rst;
      ld = load;
      lv = l;
      @(posedge clk);
      cyc++;
      if (!r)      deadline = cyc;
      else if (ld) deadline = cyc + 64'(lv);
      #1;
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   vec_t vecs[$];

   initial begin
      tests = 0;
      fails = 0;
      cyc = 0;
      deadline = 0;
      rst = 1'b1;
      load = 1'b0;
      l = '0;

      // Reset: async assertion, load ignored while low
      #2;
      set_rst(1'b0);
      #1;
      chk("rst_async_expired", 64'(expired), 64'd1);
      chk("rst_async_thr", 64'(threshold), 64'(thr_en()));
      load = 1'b1;
      l = W'(100);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rst_hold_expired", 64'(expired), 64'd1);
         chk("rst_hold_thr", 64'(threshold), 64'(thr_en()));
      end
      set_rst(1'b1);
      load = 1'b0;
      tick();
      chk("rst_release_idle", 64'(expired), 64'd1);

      // Table-driven delay vectors
      vecs.push_back('{1'b1, W'(34), 2, 1'b0, 1'b0});
      vecs.push_back('{1'b0, W'(34), 29, 1'b0, 1'b0});
      vecs.push_back('{1'b0, W'(34), 1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, W'(34), 3, 1'b0, 1'b1});
      vecs.push_back('{1'b0, W'(34), 1, 1'b1, 1'b1});
      vecs.push_back('{1'b0, W'(34), 5, 1'b1, 1'b1});
      vecs.push_back('{1'b1, W'(6), 2, 1'b0, 1'b0});
      vecs.push_back('{1'b0, W'(6), 1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, W'(6), 1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, W'(6), 3, 1'b0, 1'b1});
      vecs.push_back('{1'b0, W'(6), 1, 1'b1, 1'b1});
      vecs.push_back('{1'b1, W'(0), 1, 1'b1, 1'b1});
      vecs.push_back('{1'b1, W'(1), 1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, W'(1), 1, 1'b1, 1'b1});
      vecs.push_back('{1'b1, W'(5), 1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, W'(5), 1, 1'b0, 1'b1});
      foreach (vecs[i]) begin
         load = vecs[i].ld;
         l = vecs[i].lv;
         ticks(vecs[i].n);
         chk($sformatf("vec%0d_expired", i), 64'(expired),
             64'(vecs[i].exp_e));
         chk($sformatf("vec%0d_thr", i), 64'(threshold),
             64'(vecs[i].exp_t & thr_en()));
      end

      // Mid-count reset abandons the delay
      load = 1'b1;
      l = W'(6);
      tick();
      load = 1'b0;
      ticks(3);
      check_model("midrst_pre");
      chk("midrst_pre_count", 64'(dut.u_core.count), 64'd3);
      #2;
      set_rst(1'b0);
      #1;
      chk("midrst_async_expired", 64'(expired), 64'd1);
      chk("midrst_async_count", 64'(dut.u_core.count), 64'd0);
      @(posedge clk);
      cyc++;
      #1;
      ticks(2);
      set_rst(1'b1);
      for (int i = 0; i < 8; i++) begin
         tick();
         check_model("midrst_post");
      end

      // Held load, then restart mid-count
      load = 1'b1;
      l = W'(2000);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hold_count", 64'(dut.u_core.count), 64'd2000);
         chk("hold_expired", 64'(expired), 64'd0);
      end
      load = 1'b0;
      ticks(101);
      chk("hold_dec_count", 64'(dut.u_core.count), 64'd1899);
      load = 1'b1;
      l = W'(10);
      tick();
      load = 1'b0;
      ticks(9);
      chk("restart_pre_expired", 64'(expired), 64'd0);
      tick();
      chk("restart_expired", 64'(expired), 64'd1);

      // Full-width load value
      load = 1'b1;
      l = '1;
      tick();
      load = 1'b0;
      ticks(100);
      chk("max_count", 64'(dut.u_core.count),
          64'h0000_FFFF_FFFF_FF9B);
      chk("max_expired", 64'(expired), 64'd0);
      check_model("max");

      // Zero load, then idle saturation
      load = 1'b1;
      l = '0;
      tick();
      chk("zero_load_expired", 64'(expired), 64'd1);
      load = 1'b0;
      ticks(50);
      chk("idle_count", 64'(dut.u_core.count), 64'd0);
      check_model("idle");

      // Randomized against the deadline model
      for (int i = 0; i < 3000; i++) begin
         set_rst(($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
         load = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 19) == 0)
            l = W'({$urandom(), $urandom()});
         else
            l = W'($urandom_range(0, 40));
         tick();
         check_model("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
